// File: rtl/pipe_latch_skid_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_latch_skid_if
//  Description : Handshake bundle for one pipe_latch_skid stage. Carries the
//                upstream valid/ready/data channel, the downstream
//                valid/ready/data channel, the flush request and the status
//                outputs (occupancy, stall counter).
//                  slave  modport : seen by the pipeline stage itself
//                  master modport : seen by whatever drives and consumes it
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_latch_skid_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_latch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_latch_skid
//  Description : Generic pipeline-stage register with valid/ready handshake,
//                optional two-entry skid buffer (registered in_ready),
//                synchronous flush-to-bubble and a saturating stall counter.
//  Ports       :
//    CLK        clock, rising edge
//    nRST       asynchronous active-low reset
//    bus.in_*   upstream channel  (in_valid, in_ready, in_data)
//    bus.out_*  downstream channel (out_valid, out_ready, out_data)
//    bus.flush  discard all contents (including a same-cycle input)
//    bus.occupancy  entries held: 0, 1 or 2
//    bus.stall_cnt  saturating count of out_valid && !out_ready cycles
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_latch_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               SKID   = 1,
  parameter int               CNT_W  = 16
) (
  input  wire logic          CLK,
  input  wire logic          nRST,
  pipe_latch_skid_if.slave   bus
);

  // State encoding equals the number of held entries, so occupancy is the
  // state register itself.
  localparam logic [1:0] C_ST_EMPTY = 2'd0;
  localparam logic [1:0] C_ST_ONE   = 2'd1;
  localparam logic [1:0] C_ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic w_out_valid;
  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_out_valid = (state_q != C_ST_EMPTY);
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_out_xfer  = w_out_valid && bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: depends only on state, breaking the ready path.
      assign w_in_ready = (state_q != C_ST_TWO);
    end else begin : g_noskid
      // Single register: accept when empty or when the head leaves now.
      assign w_in_ready = !w_out_valid || bus.out_ready;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= C_ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (bus.flush) begin
      // Flush beats every handshake; an accepted input this cycle is dropped.
      state_d = C_ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        C_ST_EMPTY: begin
          if (w_in_xfer) begin
            main_d  = bus.in_data;
            state_d = C_ST_ONE;
          end
        end
        C_ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            main_d = bus.in_data;
          end else if (w_in_xfer && !w_out_xfer && (SKID != 0)) begin
            // Downstream stalled while a word was in flight: park it.
            skid_d  = bus.in_data;
            state_d = C_ST_TWO;
          end else if (!w_in_xfer && w_out_xfer) begin
            main_d  = BUBBLE;
            state_d = C_ST_EMPTY;
          end
        end
        C_ST_TWO: begin
          if (w_out_xfer) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = C_ST_ONE;
          end
        end
        default: begin
          state_d = C_ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end

    // Stall counter is independent of flush and saturates at all-ones.
    stall_d = stall_q;
    if (w_out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_out_valid;
    bus.out_data  = main_q;   // main holds BUBBLE whenever the stage is empty
    bus.occupancy = state_q;
    bus.stall_cnt = stall_q;
  end

endmodule
`default_nettype wire

// File: doc/pipe_latch_skid.md
# pipe_latch_skid

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush-to-bubble, and a saturating stall counter. It is the generic successor to the per-stage fixed-field latches and sits between any two pipeline stages (fetch/decode, decode/execute, execute/memory). Upstream and downstream may each stall independently without combinational ready paths when the skid is enabled. A flush replaces stage contents with a bubble value, for example an encoded NOP.

## Interface
- WIDTH, 32: payload width in bits; must be ≥ 1.
- BUBBLE, '0: WIDTH-bit value driven on out_data whenever the stage holds no valid entry.
- SKID, 1: 1 selects a two-entry skid with registered in_ready; 0 selects a single register with combinational in_ready.
- CNT_W, 16: width of the stall counter; must be ≥ 1.
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is a valid entry.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  WIDTH  head entry; equals BUBBLE when out_valid=0.
- flush  in  1  synchronous discard of all contents, including a same-cycle input.
- occupancy  out  2  number of held entries: 0, 1 or 2.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready.

## Operation
- State is held in two data registers, main (head) and skid, plus a state register: EMPTY, ONE or TWO. TWO is reachable only when SKID=1.
- out_valid = (state != EMPTY).
- out_data = main.
- occupancy = 0, 1 or 2 for EMPTY, ONE or TWO.
- in_ready:
  - SKID=1: in_ready = (state != TWO). It is a function of registered state only.
  - SKID=0: in_ready = !out_valid || out_ready.
- Transitions when flush=0 (in = in_valid && in_ready, out = out_valid && out_ready):
  - EMPTY: in → ONE, main<=in_data. Otherwise hold.
  - ONE, in && out: main<=in_data, stay ONE.
  - ONE, in && !out: skid<=in_data, go to TWO (SKID=1). When SKID=0 this case cannot occur, because in_ready=0.
  - ONE, !in && out: main<=BUBBLE, go to EMPTY.
  - ONE, !in && !out: hold.
  - TWO, out: main<=skid, skid<=BUBBLE, go to ONE. No input is accepted in TWO.
  - TWO, !out: hold.
- flush=1 has the highest priority over all handshakes:
  - state<=EMPTY, main<=BUBBLE, skid<=BUBBLE.
  - Any same-cycle upstream transfer is discarded.
  - Any same-cycle downstream transfer still completes, because out_data was valid in that cycle.
- stall_cnt increments when out_valid && !out_ready and saturates at 2^CNT_W−1. Flush does not clear it; only reset does.
- Entries leave in the order they were accepted. No entry is duplicated or dropped except by flush.

## Timing
- Reset (nRST=0, asynchronous) sets:
  - state EMPTY, main=BUBBLE, skid=BUBBLE.
  - out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0.
  - in_ready=1 in both modes, since out_valid=0.
- Reset deassertion is synchronous to CLK; the first transfer can occur on the first rising edge after deassertion.
- Latency: an entry accepted at edge N is presented with out_valid=1 from N until the edge at which it is consumed.
- Throughput: 1 entry/cycle sustained when out_ready=1, in both modes.
- SKID=1: in_ready falls one cycle after the first downstream stall with a held entry. The skid absorbs the in-flight word, so no entry is lost.
- Reset mid-operation discards all entries immediately. Outputs take their reset values asynchronously.
- stall_cnt updates one edge after the stall cycle it counts.

## Test plan
- Streaming, WIDTH=32, SKID=1, out_ready=1:
  - Stimulus: send 0x11, 0x22, 0x33 on consecutive cycles.
  - Response: out_data is 0x11, 0x22, 0x33 one cycle after each, out_valid stays high, occupancy stays 1, stall_cnt=0.
- Skid fill:
  - Stimulus: with 0xA0 held, drop out_ready while 0xA1 is offered.
  - Response: occupancy=2, in_ready=0 next cycle, out_data stays 0xA0.
  - Stimulus: raise out_ready.
  - Response: output order 0xA0 then 0xA1, occupancy goes 2→1→0, stall_cnt matches the number of stalled cycles.
- Flush with a simultaneous input, BUBBLE=0x00000000:
  - Stimulus: in state TWO, assert flush together with in_valid=1 (in_data=0xBEEF).
  - Response: next cycle out_valid=0, out_data=0, occupancy=0, and 0xBEEF never appears at the output.
- SKID=0 combinational ready:
  - Stimulus: hold an entry with out_ready=0.
  - Response: in_ready=0 in the same cycle.
  - Stimulus: set out_ready=1 with in_valid=1.
  - Response: in_ready=1 in the same cycle, and the entry is replaced back-to-back.
- Counter saturation, CNT_W=4:
  - Stimulus: hold out_valid=1 with out_ready=0 for 20 cycles.
  - Response: stall_cnt stops at 15.
  - Stimulus: flush.
  - Response: stall_cnt stays 15.
- Asynchronous reset mid-stream:
  - Stimulus: pulse nRST low between clock edges while occupancy=2.
  - Response: immediately out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, in_ready=1.
